// File: rtl/multiply_accumulator_16b_if.sv
// -----------------------------------------------------------------------------
// multiply_accumulator_16b_if
// Bus bundle for the signed 16x16 multiply-accumulate block.
//
// Signals (named from the MAC's point of view):
//   i_ce      clock enable for every register inside the MAC
//   i_a       16-bit two's complement multiplicand
//   i_b       16-bit two's complement multiplier
//   i_reload  load ACC_INIT_VALUE instead of accumulating this sample
//   o_p       96-bit registered accumulator value
//
// Modports:
//   master  drives the operands and control, observes o_p
//   slave   the MAC itself
// -----------------------------------------------------------------------------
interface multiply_accumulator_16b_if;
    logic        i_ce;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        i_reload;
    logic [95:0] o_p;

    modport master (
        output i_ce,
        output i_a,
        output i_b,
        output i_reload,
        input  o_p
    );

    modport slave (
        input  i_ce,
        input  i_a,
        input  i_b,
        input  i_reload,
        output o_p
    );
endinterface

// File: rtl/multiply_accumulator_16b.sv
// -----------------------------------------------------------------------------
// multiply_accumulator_16b
// Signed 16x16 multiply-accumulate primitive with a 96-bit wrapping
// accumulator, used for FIR / correlation tap sums.
//
// Pipeline:
//   [optional input register] -> product register (m) + reload bit (r)
//   -> accumulator (acc) -> o_p
//   The reload bit travels next to its own product, so the sample presented
//   with reload is replaced by ACC_INIT_VALUE and the next sample is the
//   first one added on top of it.
//
// Ports:
//   i_clk   single clock, rising edge
//   i_rst   synchronous active-high reset; clears every register, beats ce
//   mac     multiply_accumulator_16b_if.slave (i_ce, i_a, i_b, i_reload, o_p)
//
// Parameters:
//   ACC_INIT_VALUE  value the accumulator takes on reload
//   ACC_ADDSUB_OP   0 = add each product, 1 = subtract each product
//
// Build option:
//   MULACC_INREG_EN  when defined, adds an input register on a, b and reload
//                    (latency 3 instead of 2).
// -----------------------------------------------------------------------------

// Checker: after any reset edge the accumulator output must read zero.
module multiply_accumulator_16b_chk (
    input logic        i_clk,
    input logic        i_rst,
    input logic [95:0] i_p
);
    a_rst_clears_p: assert property (@(posedge i_clk) i_rst |=> (i_p == 96'd0));
endmodule

module multiply_accumulator_16b #(
    parameter logic [95:0] ACC_INIT_VALUE = 96'h0,
    parameter int          ACC_ADDSUB_OP  = 32'sd0
) (
    input logic                         i_clk,
    input logic                         i_rst,
    multiply_accumulator_16b_if.slave   mac
);

    // Operands as seen by the multiplier (either raw inputs or registered).
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic        w_reload;

    // Stage 1: sign-extended product and the reload bit that belongs to it.
    logic [95:0] w_m_next;
    logic [95:0] r_m;
    logic        r_reload;

    // Stage 2: accumulator.
    logic [95:0] w_acc_next;
    logic [95:0] r_acc;

    // Full-precision signed product, sign-extended to the accumulator width.
    // -32768 * -32768 = +2^30 still fits in the 32-bit signed intermediate.
    function automatic logic [95:0] f_sext_product(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic signed [31:0] v_prod;
        v_prod = $signed(a) * $signed(b);
        return {{64{v_prod[31]}}, v_prod};
    endfunction

`ifdef MULACC_INREG_EN
    logic [15:0] r_a_in;
    logic [15:0] r_b_in;
    logic        r_reload_in;

    // Input register: a, b and reload are captured together so reload stays
    // aligned with its own sample through the extra stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_in      <= 16'd0;
            r_b_in      <= 16'd0;
            r_reload_in <= 1'b0;
        end else if (mac.i_ce) begin
            r_a_in      <= mac.i_a;
            r_b_in      <= mac.i_b;
            r_reload_in <= mac.i_reload;
        end
    end

    assign w_a      = r_a_in;
    assign w_b      = r_b_in;
    assign w_reload = r_reload_in;
`else
    assign w_a      = mac.i_a;
    assign w_b      = mac.i_b;
    assign w_reload = mac.i_reload;
`endif

    // Multiplier: purely combinational, registered in stage 1.
    always_comb begin
        w_m_next = f_sext_product(w_a, w_b);
    end

    // Stage 1 register: product and reload bit advance only with ce, so an
    // in-flight sample is held (not lost, not repeated) while ce is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m      <= 96'd0;
            r_reload <= 1'b0;
        end else if (mac.i_ce) begin
            r_m      <= w_m_next;
            r_reload <= w_reload;
        end
    end

    // Accumulator next value: reload discards the product it travels with;
    // otherwise add or subtract, wrapping modulo 2^96.
    always_comb begin
        w_acc_next = r_acc;
        if (r_reload) begin
            w_acc_next = ACC_INIT_VALUE;
        end else if (ACC_ADDSUB_OP == 32'sd0) begin
            w_acc_next = r_acc + r_m;
        end else begin
            w_acc_next = r_acc - r_m;
        end
    end

    // Stage 2 register: the accumulator, which is also the output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= 96'd0;
        end else if (mac.i_ce) begin
            r_acc <= w_acc_next;
        end
    end

    assign mac.o_p = r_acc;

    multiply_accumulator_16b_chk u_chk (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_p   (r_acc)
    );

endmodule

// File: tb/tb_multiply_accumulator_16b.sv
// Scoreboard bench for multiply_accumulator_16b. Three instances share the
// same stimulus: default (init 0, add), init all-ones with add (wrap case),
// and a non-zero init with subtract. Directed steps carry hand-computed values
// for the result of each sample; they go through a delay line of LAT-1 cycles
// so they land on the edge where that sample shows up at p. Cycles without a
// hand value are checked against a cycle reference model.
module tb_multiply_accumulator_16b;

`ifdef MULACC_INREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [95:0] INIT0 = 96'h0;
    localparam logic [95:0] INIT1 = {96{1'b1}};
    localparam logic [95:0] INIT2 = 96'h0000_0000_0000_00AB_CDEF_0123;
    localparam logic [95:0] M10   = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFF6;

    logic        clk    = 1'b0;
    logic        tb_rst = 1'b1;
    logic        tb_ce  = 1'b1;
    logic [15:0] tb_a   = 16'd0;
    logic [15:0] tb_b   = 16'd0;
    logic        tb_rl  = 1'b0;

    always #5 clk = ~clk;

    multiply_accumulator_16b_if if0 ();
    multiply_accumulator_16b_if if1 ();
    multiply_accumulator_16b_if if2 ();

    assign if0.i_ce = tb_ce;  assign if0.i_a = tb_a;  assign if0.i_b = tb_b;  assign if0.i_reload = tb_rl;
    assign if1.i_ce = tb_ce;  assign if1.i_a = tb_a;  assign if1.i_b = tb_b;  assign if1.i_reload = tb_rl;
    assign if2.i_ce = tb_ce;  assign if2.i_a = tb_a;  assign if2.i_b = tb_b;  assign if2.i_reload = tb_rl;

    multiply_accumulator_16b #(.ACC_INIT_VALUE(INIT0), .ACC_ADDSUB_OP(0))
        dut0 (.i_clk(clk), .i_rst(tb_rst), .mac(if0));
    multiply_accumulator_16b #(.ACC_INIT_VALUE(INIT1), .ACC_ADDSUB_OP(0))
        dut1 (.i_clk(clk), .i_rst(tb_rst), .mac(if1));
    multiply_accumulator_16b #(.ACC_INIT_VALUE(INIT2), .ACC_ADDSUB_OP(1))
        dut2 (.i_clk(clk), .i_rst(tb_rst), .mac(if2));

    typedef struct {
        bit          c0;
        logic [95:0] h0;
        bit          c1;
        logic [95:0] h1;
        string       tag;
    } hand_t;

    typedef struct {
        logic [95:0] e0, e1, e2;
        string       t0, t1, t2;
    } ent_t;

    hand_t hq[$];
    ent_t  sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [15:0] md_a = 16'd0, md_b = 16'd0;
    logic        md_rl = 1'b0;
    logic [95:0] md_m = 96'd0;
    logic        md_r = 1'b0;
    logic [95:0] md_acc0 = 96'd0, md_acc1 = 96'd0, md_acc2 = 96'd0;

    task automatic model_step(input logic rst_v, input logic ce_v,
                              input logic [15:0] a_v, input logic [15:0] b_v,
                              input logic rl_v);
        logic [15:0] sa, sb;
        logic        srl;
        logic signed [95:0] ea, eb;
        if (LAT == 3) begin
            sa = md_a; sb = md_b; srl = md_rl;
        end else begin
            sa = a_v; sb = b_v; srl = rl_v;
        end
        if (rst_v) begin
            md_a = 16'd0; md_b = 16'd0; md_rl = 1'b0;
            md_m = 96'd0; md_r = 1'b0;
            md_acc0 = 96'd0; md_acc1 = 96'd0; md_acc2 = 96'd0;
        end else if (ce_v) begin
            md_acc0 = md_r ? INIT0 : md_acc0 + md_m;
            md_acc1 = md_r ? INIT1 : md_acc1 + md_m;
            md_acc2 = md_r ? INIT2 : md_acc2 - md_m;
            ea = $signed(sa);
            eb = $signed(sb);
            md_m  = ea * eb;
            md_r  = srl;
            md_a  = a_v; md_b = b_v; md_rl = rl_v;
        end
    endtask

    // One clock of stimulus; queues the expected p after this cycle's edge.
    task automatic step(input logic rst_v, input logic ce_v,
                        input logic [15:0] a_v, input logic [15:0] b_v, input logic rl_v,
                        input bit c0, input logic [95:0] h0,
                        input bit c1, input logic [95:0] h1, input string tag);
        hand_t h, hd;
        ent_t  e;
        @(negedge clk);
        tb_rst = rst_v; tb_ce = ce_v; tb_a = a_v; tb_b = b_v; tb_rl = rl_v;
        model_step(rst_v, ce_v, a_v, b_v, rl_v);
        h.c0 = c0; h.h0 = h0; h.c1 = c1; h.h1 = h1; h.tag = tag;
        hq.push_back(h);
        hd = hq.pop_front();
        e.e0 = hd.c0 ? hd.h0 : md_acc0;
        e.t0 = hd.c0 ? hd.tag : "model";
        e.e1 = hd.c1 ? hd.h1 : md_acc1;
        e.t1 = hd.c1 ? hd.tag : "model";
        e.e2 = md_acc2;
        e.t2 = "model";
        sbq.push_back(e);
    endtask

    // Directed sample with a hand value for dut0.
    task automatic dv(input logic [15:0] a_v, input logic [15:0] b_v, input logic rl_v,
                      input logic [95:0] h0, input string tag);
        step(1'b0, 1'b1, a_v, b_v, rl_v, 1'b1, h0, 1'b0, 96'd0, tag);
    endtask

    task automatic cmp(input logic [95:0] act, input logic [95:0] exp, input string nm, input int idx);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: p=%h expected %h", nm, idx, act, exp);
        end
    endtask

    // Monitor: compares every DUT output just after each rising edge.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                cmp(if0.o_p, e.e0, e.t0, 0);
                cmp(if1.o_p, e.e1, e.t1, 1);
                cmp(if2.o_p, e.e2, e.t2, 2);
            end
        end
    end

    initial begin
        for (int i = 0; i < LAT - 1; i++) begin
            hand_t h;
            h.c0 = 1'b0; h.h0 = 96'd0; h.c1 = 1'b0; h.h1 = 96'd0; h.tag = "prefill";
            hq.push_back(h);
        end

        // Reset with random operands.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 96'd0, 1'b0, 96'd0, "reset");
        dv(16'd0, 16'd0, 1'b0, 96'd0, "post_reset");
        dv(16'd0, 16'd0, 1'b0, 96'd0, "post_reset");

        // Latency and sign.
        dv(16'hFFFE, 16'd5, 1'b0, M10, "neg_product");
        dv(16'd0, 16'd0, 1'b0, M10, "neg_hold");
        dv(16'd0, 16'd0, 1'b0, M10, "neg_hold");

        // Accumulate then reload.
        dv(16'd0, 16'd0, 1'b1, 96'd0, "reload0");
        dv(16'd3, 16'd4, 1'b0, 96'd12, "acc_3x4");
        dv(16'hFFFF, 16'd7, 1'b0, 96'd5, "acc_m1x7");
        dv(16'd100, 16'd100, 1'b0, 96'd10005, "acc_100x100");
        dv(16'd5, 16'd5, 1'b1, 96'd0, "reload_excl");
        dv(16'd2, 16'd2, 1'b0, 96'd4, "after_reload");
        dv(16'd0, 16'hFED4, 1'b0, 96'd4, "zero_operand");
        dv(16'd0, 16'd0, 1'b0, 96'd4, "hold");

        // Clock enable.
        dv(16'd0, 16'd0, 1'b1, 96'd0, "reload1");
        dv(16'd2, 16'd3, 1'b0, 96'd6, "acc_2x3");
        dv(16'd0, 16'd0, 1'b0, 96'd6, "settle");
        dv(16'd0, 16'd0, 1'b0, 96'd6, "settle");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 96'd6, 1'b0, 96'd0, "ce_low_hold");
        dv(16'd1, 16'd1, 1'b0, 96'd7, "ce_resume");
        dv(16'd0, 16'd0, 1'b0, 96'd7, "ce_after");

        // Extremes.
        dv(16'd0, 16'd0, 1'b1, 96'd0, "reload2");
        dv(16'h8000, 16'h8000, 1'b0, 96'h4000_0000, "min_x_min1");
        dv(16'h8000, 16'h8000, 1'b0, 96'h8000_0000, "min_x_min2");
        dv(16'h8000, 16'h8000, 1'b0, 96'hC000_0000, "min_x_min3");
        dv(16'h8000, 16'h8000, 1'b0, 96'h1_0000_0000, "min_x_min4");
        dv(16'd0, 16'd0, 1'b0, 96'h1_0000_0000, "min_hold");

        // Wrap on the all-ones init instance.
        step(1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 96'd0, 1'b1, INIT1, "wrap_reload");
        step(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 96'd1, 1'b1, 96'd0, "wrap_1x1");
        step(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b1, 96'd1, 1'b1, 96'd0, "wrap_hold");

        // Reset mid-operation, with ce low and reload high.
        dv(16'd7, 16'd7, 1'b0, 96'd50, "pre_rst");
        dv(16'd0, 16'd0, 1'b0, 96'd50, "pre_rst_hold");
        dv(16'd0, 16'd0, 1'b0, 96'd50, "pre_rst_hold");
        step(1'b0, 1'b1, 16'd9, 16'd9, 1'b0, 1'b0, 96'd0, 1'b0, 96'd0, "inflight");
        step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 96'd0, 1'b0, 96'd0, "mid_rst");
        for (int i = 0; i < 3; i++)
            dv(16'd0, 16'd0, 1'b0, 96'd0, "after_mid_rst");

        // Random traffic against the reference model.
        for (int i = 0; i < 5000; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            step(1'b0, 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 31) == 0),
                 1'b0, 96'd0, 1'b0, 96'd0, "random");
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 96'd0, 1'b0, 96'd0, "tail");

        for (int i = 0; i < 20 && sbq.size() != 0; i++)
            @(negedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
